tag_scoreboard: RTL and testbench
=================================

Name: tag_scoreboard

Overview:
Physical-tag allocator and completion scoreboard. Sits upstream of the sequential issue buffer.
- Hands free 5-bit result tags to the rename stage.
- Clears a tag's done flag on allocation and sets it on execution writeback.
- Returns tags to the free pool on retire.
- Drives the 30-bit done_flags vector that every issue entry compares against its source tags.

Parameters:
NUM_TAGS, 30, number of physical result tags; must match the done_flags width (max 32).
TAG_W, 5, tag index width; ceil(log2(NUM_TAGS)).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low (asserted when 0).
alloc_valid  output  1  a free tag is offered.
alloc_ready  input  1  rename consumes the offered tag.
alloc_tag  output  TAG_W  offered tag: lowest-index free tag.
wb_valid  input  1  writeback strobe from execution.
wb_tag  input  TAG_W  tag whose result is now available.
free_valid  input  1  retire strobe.
free_tag  input  TAG_W  tag returned to the pool.
done_flags  output  NUM_TAGS  bit i = tag i result available (or tag free).
free_count  output  TAG_W+1  number of free tags.
err_sticky  output  1  protocol violation seen; cleared only by reset.

Behaviour:
- State: free bitmap[NUM_TAGS], done bitmap[NUM_TAGS], free counter, error flag. No other FSM.
- Reset (rst=0, async):
  - free = all 1; done = all 1.
  - free_count = NUM_TAGS; err_sticky = 0.
  - Outputs out of reset: alloc_valid = 1, alloc_tag = 0.
- alloc_valid = |free (combinational from registered state).
- alloc_tag = priority-encoded lowest set bit of free. When free is empty, alloc_tag = 0 and alloc_valid = 0.
- Allocation handshake = alloc_valid & alloc_ready. Next cycle:
  - free[alloc_tag] = 0 and done[alloc_tag] = 0;
  - free_count decrements by 1.
  - alloc_ready with alloc_valid=0 has no effect.
- Writeback: wb_valid with wb_tag < NUM_TAGS and free[wb_tag] = 0 sets done[wb_tag] = 1 next cycle.
  - Writeback to a free tag: no state change; err_sticky = 1.
  - Writeback to an already-done busy tag: no change, no error.
- Free: free_valid with free[free_tag] = 0 sets free[free_tag] = 1 and done[free_tag] = 1 next cycle; free_count increments.
  - Double free (tag already free): ignored; err_sticky = 1.
- Out-of-range tags (>= NUM_TAGS) on wb or free are ignored and set err_sticky.
- Simultaneous events in one cycle:
  - alloc + free of different tags: free_count unchanged.
  - A tag freed at cycle n is first offerable at n+1; no same-cycle recycling.
  - wb and free on the same tag: free wins; final state free=1, done=1.
  - alloc and wb cannot legally hit the same tag (an offered tag is free). If they do, the wb is flagged as error and the alloc proceeds: done=0.
- Full/empty:
  - free_count = 0 → alloc_valid = 0.
  - free_count = NUM_TAGS with no busy tags → wb and free both error.
- done_flags = done register; one-cycle latency from wb_valid.
- Reset mid-operation: all in-flight tags become free and done immediately on rst fall; pending strobes are dropped.

Optional Feature:
SCOREBOARD_WB_BYPASS_EN
- Defined: done_flags = done | (legal wb_valid decoded one-hot), giving same-cycle wakeup. Register behaviour is unchanged.
- Undefined: done_flags is purely registered (1-cycle wb-to-flag latency).

Decomposition:
- Shared package/header holds NUM_TAGS, TAG_W and the tag-to-one-hot decode width, so the issue buffer and rename stage agree on the done_flags width.
- One natural sub-module: tag_prio_enc, a parameterised lowest-set-bit encoder producing (valid, index) from the free bitmap.

Test Plan:
- Release reset; hold alloc_ready=1 for 30 cycles → tags 0..29 issued in order; then alloc_valid=0, free_count=0, done_flags=0.
- After filling, wb_tag=7 → done_flags bit 7 = 1 next cycle (same cycle with SCOREBOARD_WB_BYPASS_EN); others stay 0.
- free_tag=12 while full → next cycle alloc_valid=1, alloc_tag=12, free_count=1, done bit 12 = 1.
- Same cycle: alloc handshake on tag 3 and free of tag 20 → free_count unchanged; tag 3 busy with done=0; tag 20 free with done=1.
- free_tag=5 twice (second while free) → second ignored, err_sticky=1, free_count incremented once only; wb_tag=31 → ignored.
- Assert rst=0 mid-run with 10 tags busy → immediately free_count=30, done_flags all 1, err_sticky=0, alloc_tag=0.

Source files
------------

// File: rtl/tag_scoreboard_pkg.sv
// Shared tag-space constants and the tag-to-one-hot decode used by the scoreboard,
// the issue buffer and the rename stage, so all agree on the done_flags width.
// Combinational helpers only; no state.
package tag_scoreboard_pkg;

    localparam int NUM_TAGS = 30;  // physical result tags (max 32)
    localparam int TAG_W    = 5;   // ceil(log2(NUM_TAGS))
    localparam int OH_W     = NUM_TAGS;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [OH_W-1:0]  tag_vec_t;

    // Out-of-range tags decode to all zeros, so they can never hit a bitmap bit.
    function automatic tag_vec_t tag_onehot(input tag_t tag);
        tag_vec_t oh;
        oh = '0;
        for (int i = 0; i < OH_W; i++) begin
            oh[i] = (tag == TAG_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/tag_prio_enc.sv
// Lowest-set-bit priority encoder: (valid, index) of the lowest 1 in in_vec.
// Latency: purely combinational. Backpressure: none.
// Index is 0 when no bit is set.
module tag_prio_enc #(
    parameter int W  = 30,
    parameter int IW = 5
) (
    input  logic [W-1:0]  in_vec,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign vld = |in_vec;

endmodule

// File: rtl/tag_scoreboard.sv
// Physical-tag allocator and completion scoreboard driving done_flags to the issue buffer.
// Latency: alloc/wb/free update state next cycle; done_flags 1 cycle after wb
// (same cycle when SCOREBOARD_WB_BYPASS_EN is defined). Backpressure: alloc_valid drops when no tag is free.
module tag_scoreboard
    import tag_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    output logic                alloc_valid,
    input  logic                alloc_ready,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                wb_valid,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic                free_valid,
    input  logic [TAG_W-1:0]    free_tag,
    output logic [NUM_TAGS-1:0] done_flags,
    output logic [TAG_W:0]      free_count,
    output logic                err_sticky
);

    logic [NUM_TAGS-1:0] free_q, free_d;
    logic [NUM_TAGS-1:0] done_q, done_d;
    logic [TAG_W:0]      cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [NUM_TAGS-1:0] wb_oh, free_oh, alloc_oh;
    logic                alloc_fire, wb_legal, free_legal;

    tag_prio_enc #(
        .W  (NUM_TAGS),
        .IW (TAG_W)
    ) u_prio_enc (
        .in_vec (free_q),
        .vld    (alloc_valid),
        .idx    (alloc_tag)
    );

    assign wb_oh    = tag_onehot(wb_tag);
    assign free_oh  = tag_onehot(free_tag);
    assign alloc_oh = tag_onehot(alloc_tag);

    // A strobe is legal only if its tag is in range and currently busy; the
    // one-hot decode is zero for out-of-range tags, which folds both tests together.
    assign alloc_fire = alloc_valid & alloc_ready;
    assign wb_legal   = wb_valid & (|(wb_oh & ~free_q));
    assign free_legal = free_valid & (|(free_oh & ~free_q));

    // Next-state: wb sets done, free overrides wb, alloc clears last. An offered
    // tag is always free, so alloc never collides with a legal wb or free.
    always_comb begin
        free_d = free_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (wb_legal) begin
            done_d = done_d | wb_oh;
        end
        if (free_legal) begin
            free_d = free_d | free_oh;
            done_d = done_d | free_oh;
        end
        if (alloc_fire) begin
            free_d = free_d & ~alloc_oh;
            done_d = done_d & ~alloc_oh;
        end
        if (free_legal && !alloc_fire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (alloc_fire && !free_legal) begin
            cnt_d = cnt_q - 1'b1;
        end
        if ((wb_valid && !wb_legal) || (free_valid && !free_legal)) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset returns every tag to free and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_q <= '1;
            done_q <= '1;
            cnt_q  <= (TAG_W + 1)'(NUM_TAGS);
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Same-cycle wakeup: forward a legal writeback straight onto the flags.
    assign done_flags = done_q | (wb_legal ? wb_oh : '0);
`else
    assign done_flags = done_q;
`endif

    assign free_count = cnt_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_tag_scoreboard.sv
// Directed bench for tag_scoreboard: fill, writeback, free, simultaneous events,
// error cases and mid-run reset, with hand-computed expected values.
module tb_tag_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid;
    logic        alloc_ready = 1'b0;
    logic [4:0]  alloc_tag;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_tag = '0;
    logic        free_valid = 1'b0;
    logic [4:0]  free_tag = '0;
    logic [29:0] done_flags;
    logic [5:0]  free_count;
    logic        err_sticky;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [29:0] ALL1 = {30{1'b1}};

    tag_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .free_valid  (free_valid),
        .free_tag    (free_tag),
        .done_flags  (done_flags),
        .free_count  (free_count),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_ready = 1'b0;
        wb_valid    = 1'b0;
        free_valid  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #12;
        n_total++; if (alloc_valid !== 1'b1) $display("FAIL reset_alloc_valid got %0b want 1", alloc_valid); else n_pass++;
        n_total++; if (alloc_tag !== 5'd0) $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag); else n_pass++;
        n_total++; if (free_count !== 6'd30) $display("FAIL reset_free_count got %0d want 30", free_count); else n_pass++;
        n_total++; if (done_flags !== ALL1) $display("FAIL reset_done got %h want %h", done_flags, ALL1); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL reset_err got %0b want 0", err_sticky); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        int bad = 0;
        alloc_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (alloc_valid !== 1'b1 || alloc_tag !== 5'(i)) begin
                if (bad == 0) $display("FAIL fill_order step %0d got v=%0b tag=%0d want v=1 tag=%0d", i, alloc_valid, alloc_tag, i);
                bad++;
            end
            tick();
        end
        n_total++; if (bad == 0) n_pass++;
        // alloc_ready held while empty must be harmless
        tick();
        alloc_ready = 1'b0;
        n_total++; if (alloc_valid !== 1'b0) $display("FAIL full_alloc_valid got %0b want 0", alloc_valid); else n_pass++;
        n_total++; if (alloc_tag !== 5'd0) $display("FAIL full_alloc_tag got %0d want 0", alloc_tag); else n_pass++;
        n_total++; if (free_count !== 6'd0) $display("FAIL full_free_count got %0d want 0", free_count); else n_pass++;
        n_total++; if (done_flags !== 30'd0) $display("FAIL full_done got %h want 0", done_flags); else n_pass++;
    endtask

    task automatic test_writeback();
        wb_valid = 1'b1;
        wb_tag   = 5'd7;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        n_total++; if (done_flags !== 30'h80) $display("FAIL wb_bypass got %h want %h", done_flags, 30'h80); else n_pass++;
`else
        n_total++; if (done_flags !== 30'd0) $display("FAIL wb_not_early got %h want 0", done_flags); else n_pass++;
`endif
        tick();
        idle();
        n_total++; if (done_flags !== 30'h80) $display("FAIL wb_done got %h want %h", done_flags, 30'h80); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL wb_err got %0b want 0", err_sticky); else n_pass++;
    endtask

    task automatic test_free_when_full();
        free_valid = 1'b1;
        free_tag   = 5'd12;
        tick();
        idle();
        n_total++; if (alloc_valid !== 1'b1 || alloc_tag !== 5'd12) $display("FAIL free12_offer got v=%0b tag=%0d want v=1 tag=12", alloc_valid, alloc_tag); else n_pass++;
        n_total++; if (free_count !== 6'd1) $display("FAIL free12_count got %0d want 1", free_count); else n_pass++;
        n_total++; if (done_flags !== 30'h1080) $display("FAIL free12_done got %h want %h", done_flags, 30'h1080); else n_pass++;
    endtask

    task automatic test_alloc_and_free();
        // free tag 3 so it becomes the lowest offered tag
        free_valid = 1'b1;
        free_tag   = 5'd3;
        tick();
        idle();
        n_total++; if (alloc_tag !== 5'd3 || free_count !== 6'd2) $display("FAIL free3 got tag=%0d cnt=%0d want tag=3 cnt=2", alloc_tag, free_count); else n_pass++;
        alloc_ready = 1'b1;
        free_valid  = 1'b1;
        free_tag    = 5'd20;
        tick();
        idle();
        n_total++; if (free_count !== 6'd2) $display("FAIL simul_count got %0d want 2", free_count); else n_pass++;
        n_total++; if (done_flags !== 30'h101080) $display("FAIL simul_done got %h want %h", done_flags, 30'h101080); else n_pass++;
        n_total++; if (alloc_tag !== 5'd12) $display("FAIL simul_next_tag got %0d want 12", alloc_tag); else n_pass++;
    endtask

    task automatic test_double_free();
        free_valid = 1'b1;
        free_tag   = 5'd5;
        tick();
        n_total++; if (free_count !== 6'd3 || err_sticky !== 1'b0) $display("FAIL free5_first got cnt=%0d err=%0b want cnt=3 err=0", free_count, err_sticky); else n_pass++;
        tick();
        idle();
        n_total++; if (free_count !== 6'd3) $display("FAIL free5_twice_count got %0d want 3", free_count); else n_pass++;
        n_total++; if (err_sticky !== 1'b1) $display("FAIL free5_twice_err got %0b want 1", err_sticky); else n_pass++;
        n_total++; if (done_flags !== 30'h1010A0) $display("FAIL free5_done got %h want %h", done_flags, 30'h1010A0); else n_pass++;
    endtask

    task automatic test_wb_free_same();
        wb_valid   = 1'b1;
        wb_tag     = 5'd9;
        free_valid = 1'b1;
        free_tag   = 5'd9;
        tick();
        idle();
        n_total++; if (free_count !== 6'd4) $display("FAIL wbfree_count got %0d want 4", free_count); else n_pass++;
        n_total++; if (done_flags !== 30'h1012A0) $display("FAIL wbfree_done got %h want %h", done_flags, 30'h1012A0); else n_pass++;
        n_total++; if (alloc_tag !== 5'd5) $display("FAIL wbfree_tag got %0d want 5", alloc_tag); else n_pass++;
    endtask

    task automatic test_reset_mid();
        // pending strobes in flight when reset hits must be dropped
        alloc_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 5'd31;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (free_count !== 6'd30) $display("FAIL midrst_count got %0d want 30", free_count); else n_pass++;
        n_total++; if (done_flags !== ALL1) $display("FAIL midrst_done got %h want %h", done_flags, ALL1); else n_pass++;
        n_total++; if (err_sticky !== 1'b0 || alloc_tag !== 5'd0) $display("FAIL midrst_err_tag got err=%0b tag=%0d want err=0 tag=0", err_sticky, alloc_tag); else n_pass++;
        idle();
        #10;
        rst = 1'b1;
        tick();
        n_total++; if (free_count !== 6'd30 || err_sticky !== 1'b0) $display("FAIL midrst_hold got cnt=%0d err=%0b want cnt=30 err=0", free_count, err_sticky); else n_pass++;
    endtask

    task automatic test_errors();
        // out-of-range writeback
        wb_valid = 1'b1;
        wb_tag   = 5'd31;
        tick();
        idle();
        n_total++; if (err_sticky !== 1'b1 || done_flags !== ALL1 || free_count !== 6'd30) $display("FAIL wb31 got err=%0b done=%h cnt=%0d want err=1 done=%h cnt=30", err_sticky, done_flags, free_count, ALL1); else n_pass++;
        do_reset();
        // writeback to a free tag
        wb_valid = 1'b1;
        wb_tag   = 5'd4;
        tick();
        idle();
        n_total++; if (err_sticky !== 1'b1) $display("FAIL wb_free_tag_err got %0b want 1", err_sticky); else n_pass++;
        do_reset();
        // free of an already-free tag when nothing is busy
        free_valid = 1'b1;
        free_tag   = 5'd4;
        tick();
        idle();
        n_total++; if (err_sticky !== 1'b1 || free_count !== 6'd30) $display("FAIL free_empty got err=%0b cnt=%0d want err=1 cnt=30", err_sticky, free_count); else n_pass++;
        do_reset();
        // alloc and wb on the same offered tag: wb errors, alloc proceeds with done=0
        alloc_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 5'd0;
        #1;
        n_total++; if (done_flags !== ALL1) $display("FAIL allocwb_nobypass got %h want %h", done_flags, ALL1); else n_pass++;
        tick();
        idle();
        n_total++; if (err_sticky !== 1'b1 || free_count !== 6'd29) $display("FAIL allocwb got err=%0b cnt=%0d want err=1 cnt=29", err_sticky, free_count); else n_pass++;
        n_total++; if (done_flags !== {{29{1'b1}}, 1'b0} || alloc_tag !== 5'd1) $display("FAIL allocwb_state got done=%h tag=%0d want done=%h tag=1", done_flags, alloc_tag, {{29{1'b1}}, 1'b0}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_writeback();
        test_free_when_full();
        test_alloc_and_free();
        test_double_free();
        test_wb_free_same();
        test_reset_mid();
        test_errors();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
